dma_timing_fsm_multi: RTL and testbench

//  Parametrised DMA transfer timing controller for NUM_CH channels.
//  - Arbitrates DREQs and runs the HRQ/HLDA handshake.
//  - Sequences SI/S0/S1/S2/S3/SW/S4 and drives bus strobes.
//  - Supports single, block and demand modes, READY wait states, extended write, compressed bursts.
//  - Supports fixed or rotating priority and TC/external EOP termination.
//  - Sits between the command/mode register file and the address/word datapath.

---
 rtl/dma_timing_fsm_multi.sv | 152 +++++++++++++++
 tb/tb_dma_timing_fsm_multi.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_timing_fsm_multi.sv
// dma_timing_fsm_multi: multi-channel DMA transfer timing controller (arbitration, hold handshake, bus strobes)
module dma_timing_fsm_multi #(
    parameter int NUM_CH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_CH-1:0]     DREQ,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [2*NUM_CH-1:0]   xfer_type,
    input  logic [2*NUM_CH-1:0]   xfer_mode,
    input  logic                  cmd_disable,
    input  logic                  cmd_compress,
    input  logic                  cmd_ext_wr,
    input  logic                  cmd_rot_prio,
    input  logic                  cmd_dreq_low,
    input  logic                  cmd_dack_hi,
    input  logic                  HLDA,
    input  logic                  READY,
    input  logic                  EOP_N_IN,
    input  logic                  tc_i,
    input  logic                  hi_addr_chg,
    output logic                  HRQ,
    output logic                  AEN,
    output logic                  ADSTB,
    output logic [NUM_CH-1:0]     DACK,
    output logic                  MEMR_N,
    output logic                  MEMW_N,
    output logic                  IOR_N,
    output logic                  IOW_N,
    output logic                  EOP_N_OUT,
    output logic [NUM_CH-1:0]     ch_sel,
    output logic                  dp_step,
    output logic [NUM_CH-1:0]     tc_set
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4} stateT;

    stateT             state, nextState;
    logic [NUM_CH-1:0] chSel, winner, vreq, dackAct;
    logic [CH_W-1:0]   rotPtr, actIdx;
    logic [1:0]        actType, actMode;
    logic              eopLatch, rdStb, wrStb, done, stop, abort;
    int                pos;

    assign vreq    = (DREQ ^ {NUM_CH{cmd_dreq_low}}) & ~ch_mask & {NUM_CH{~cmd_disable}};
    assign actType = xfer_type[{actIdx, 1'b0} +: 2];
    assign actMode = xfer_mode[{actIdx, 1'b0} +: 2];
    assign HRQ     = state != SI;
    assign ch_sel  = chSel;
    assign abort   = !HLDA && state inside {S1, S2, S3, SW, S4};
    assign stop    = tc_i || eopLatch || actMode[0] || (actMode == 2'b00 && !(|(vreq & chSel)));
    assign MEMR_N  = !(rdStb && actType == 2'b10);
    assign IOR_N   = !(rdStb && actType == 2'b01);
    assign IOW_N   = !(wrStb && actType == 2'b10);
    assign MEMW_N  = !(wrStb && actType == 2'b01);
    assign DACK    = cmd_dack_hi ? dackAct : ~dackAct;

    // Priority search from lowest to highest priority so the highest-priority requester is written last
    always_comb begin
        winner = '0;
        pos = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            pos = cmd_rot_prio ? (int'(rotPtr) + 1 + i) % NUM_CH : i;
            if (vreq[pos[CH_W-1:0]]) begin
                winner = '0;
                winner[pos[CH_W-1:0]] = 1'b1;
            end
        end
    end

    // Binary index of the channel being served, used to pick its mode and type fields
    always_comb begin
        actIdx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (chSel[i]) actIdx = CH_W'(i);
    end

    // Next-state and bus outputs; a dropped HLDA overrides everything and releases the bus
    always_comb begin
        nextState = state;
        AEN       = 1'b0;
        ADSTB     = 1'b0;
        dackAct   = '0;
        rdStb     = 1'b0;
        wrStb     = 1'b0;
        dp_step   = 1'b0;
        tc_set    = '0;
        EOP_N_OUT = 1'b1;
        done      = 1'b0;
        case (state)
            SI: nextState = |vreq ? S0 : SI;
            S0: nextState = !(|vreq) ? SI : HLDA ? S1 : S0;
            S1: begin
                AEN       = 1'b1;
                ADSTB     = 1'b1;
                nextState = S2;
            end
            S2: begin
                AEN       = 1'b1;
                dackAct   = chSel;
                rdStb     = 1'b1;
                wrStb     = cmd_ext_wr;
                nextState = S3;
            end
            S3, SW: begin
                AEN       = 1'b1;
                dackAct   = chSel;
                rdStb     = 1'b1;
                wrStb     = 1'b1;
                nextState = READY ? S4 : SW;
            end
            S4: begin
                AEN       = 1'b1;
                dackAct   = chSel;
                dp_step   = 1'b1;
                EOP_N_OUT = !tc_i;
                tc_set    = tc_i ? chSel : '0;
                done      = stop;
                nextState = stop ? SI : hi_addr_chg ? S1 : cmd_compress ? S3 : S2;
            end
            default: nextState = SI;
        endcase
        if (abort) begin
            nextState = SI;
            AEN       = 1'b0;
            ADSTB     = 1'b0;
            dackAct   = '0;
            rdStb     = 1'b0;
            wrStb     = 1'b0;
            dp_step   = 1'b0;
            tc_set    = '0;
            EOP_N_OUT = 1'b1;
            done      = 1'b0;
        end
    end

    // State, served channel, rotation pointer and external-EOP latch
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= SI;
            chSel    <= '0;
            rotPtr   <= CH_W'(NUM_CH - 1);
            eopLatch <= 1'b0;
        end else begin
            state    <= nextState;
            chSel    <= nextState == SI ? '0 : (state == S0 && nextState == S1) ? winner : chSel;
            rotPtr   <= done ? actIdx : rotPtr;
            eopLatch <= state == SI ? 1'b0 : (state inside {S2, S3, SW} && !EOP_N_IN) ? 1'b1 : eopLatch;
        end
    end
endmodule

// File: tb/tb_dma_timing_fsm_multi.sv
// tb_dma_timing_fsm_multi: scoreboard bench, one expected record per dp_step pulse
module tb_dma_timing_fsm_multi;
    logic       CLK, RESET;
    logic [3:0] DREQ, ch_mask;
    logic [7:0] xfer_type, xfer_mode;
    logic       cmd_disable, cmd_compress, cmd_ext_wr, cmd_rot_prio, cmd_dreq_low, cmd_dack_hi;
    logic       HLDA, READY, EOP_N_IN, tc_i, hi_addr_chg;
    logic       HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT, dp_step;
    logic [3:0] DACK, ch_sel, tc_set;

    dma_timing_fsm_multi #(.NUM_CH(4)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .ch_mask(ch_mask),
        .xfer_type(xfer_type), .xfer_mode(xfer_mode),
        .cmd_disable(cmd_disable), .cmd_compress(cmd_compress), .cmd_ext_wr(cmd_ext_wr),
        .cmd_rot_prio(cmd_rot_prio), .cmd_dreq_low(cmd_dreq_low), .cmd_dack_hi(cmd_dack_hi),
        .HLDA(HLDA), .READY(READY), .EOP_N_IN(EOP_N_IN), .tc_i(tc_i), .hi_addr_chg(hi_addr_chg),
        .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .DACK(DACK),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .EOP_N_OUT(EOP_N_OUT), .ch_sel(ch_sel), .dp_step(dp_step), .tc_set(tc_set)
    );

    typedef struct packed {
        logic [3:0] ch;
        logic [3:0] dack;
        logic [3:0] tc;
        logic       eop;
        logic [3:0] memr;
        logic [3:0] memw;
        logic [3:0] ior;
        logic [3:0] iow;
    } recT;

    recT        expQ[$];
    int         checks = 0;
    int         failures = 0;
    bit         hldaEn = 1;
    bit         ok;
    logic [3:0] cMemr = 0, cMemw = 0, cIor = 0, cIow = 0;
    logic [20:0] busVec;

    localparam logic [20:0] IDLE = {5'b11111, 16'b0};
    assign busVec = {MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_OUT, HRQ, AEN, ADSTB, dp_step, ch_sel, DACK, tc_set};

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // CPU model: grants hold one clock after the request, unless disabled for the abort case
    initial begin
        HLDA = 0;
        forever begin
            @(posedge CLK);
            #1 HLDA = HRQ && hldaEn;
        end
    end

    // Monitor: counts strobe-low cycles per transfer and checks each dp_step against the queue
    initial begin
        recT obs, exp;
        forever begin
            @(negedge CLK);
            if (!MEMR_N) cMemr++;
            if (!MEMW_N) cMemw++;
            if (!IOR_N) cIor++;
            if (!IOW_N) cIow++;
            if (dp_step) begin
                obs = '{ch_sel, DACK, tc_set, EOP_N_OUT, cMemr, cMemw, cIor, cIow};
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL step_unexpected: got ch=%b dack=%b tc=%b eop=%b memr=%0d memw=%0d ior=%0d iow=%0d with nothing expected",
                             obs.ch, obs.dack, obs.tc, obs.eop, obs.memr, obs.memw, obs.ior, obs.iow);
                end else begin
                    exp = expQ.pop_front();
                    if (obs !== exp) begin
                        failures++;
                        $display("FAIL step: got ch=%b dack=%b tc=%b eop=%b memr=%0d memw=%0d ior=%0d iow=%0d expected ch=%b dack=%b tc=%b eop=%b memr=%0d memw=%0d ior=%0d iow=%0d",
                                 obs.ch, obs.dack, obs.tc, obs.eop, obs.memr, obs.memw, obs.ior, obs.iow,
                                 exp.ch, exp.dack, exp.tc, exp.eop, exp.memr, exp.memw, exp.ior, exp.iow);
                    end
                end
            end
            if (dp_step || !HRQ) {cMemr, cMemw, cIor, cIow} = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic push(input logic [3:0] ch, dack, tc, input logic eop, input logic [3:0] memr, memw, ior, iow);
        expQ.push_back('{ch, dack, tc, eop, memr, memw, ior, iow});
    endtask

    // sel: 0 ADSTB high, 1 IOW_N low, 2 dp_step, 3 HRQ low
    task automatic waitFor(input string name, input int sel, output bit hit);
        hit = 0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge CLK);
            hit = sel == 0 ? ADSTB : sel == 1 ? !IOW_N : sel == 2 ? dp_step : !HRQ;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: timed out after 100 cycles waiting for event %0d", name, sel);
        end
    endtask

    task automatic runSteps(input int n, input int tcAt);
        bit hit;
        for (int i = 1; i <= n; i++) begin
            tc_i = i == tcAt;
            waitFor("step_wait", 2, hit);
            if (!hit) break;
            @(posedge CLK);
            #1;
        end
        DREQ = '0;
        tc_i = 0;
    endtask

    task automatic waitIdle();
        bit hit;
        waitFor("idle_wait", 3, hit);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1; DREQ = 0; ch_mask = 0; xfer_type = 0; xfer_mode = 0;
        cmd_disable = 0; cmd_compress = 0; cmd_ext_wr = 0; cmd_rot_prio = 0;
        cmd_dreq_low = 0; cmd_dack_hi = 1; READY = 1; EOP_N_IN = 1; tc_i = 0; hi_addr_chg = 0;
        #1 check("reset_outputs", 32'(busVec), 32'(IDLE));
        #20 RESET = 0;
        @(posedge CLK); #1;

        // single read ch2
        xfer_type = 8'b00_10_00_00; xfer_mode = 8'b00_01_00_00;
        push(4'b0100, 4'b0100, 4'b0000, 1, 2, 0, 0, 1);
        DREQ = 4'b0100;
        @(negedge CLK) check("hrq_latency_first", 32'(HRQ), 0);
        @(negedge CLK) check("hrq_latency_second", 32'(HRQ), 1);
        runSteps(1, 0);
        waitIdle();
        check("idle_after_single", 32'(busVec), 32'(IDLE));

        // compressed block write ch0, terminal count on third transfer
        xfer_type = 8'b00_00_00_01; xfer_mode = 8'b00_00_00_10; cmd_compress = 1;
        push(4'b0001, 4'b0001, 4'b0000, 1, 0, 1, 2, 0);
        push(4'b0001, 4'b0001, 4'b0000, 1, 0, 1, 1, 0);
        push(4'b0001, 4'b0001, 4'b0001, 0, 0, 1, 1, 0);
        DREQ = 4'b0001;
        runSteps(3, 3);
        cmd_compress = 0;
        waitIdle();

        // three READY wait states on single read ch2
        xfer_type = 8'b00_10_00_00; xfer_mode = 8'b00_01_00_00; READY = 0;
        push(4'b0100, 4'b0100, 4'b0000, 1, 5, 0, 0, 4);
        DREQ = 4'b0100;
        waitFor("s3_wait", 1, ok);
        repeat (3) @(posedge CLK);
        #1 check("wait_state_hold", 32'({dp_step, IOW_N, MEMR_N}), 0);
        READY = 1;
        runSteps(1, 0);
        waitIdle();

        // reset restores rotation pointer; rotating priority with all channels requesting
        RESET = 1; #10 RESET = 0;
        @(posedge CLK); #1;
        cmd_rot_prio = 1; xfer_type = 8'b10_01_00_11; xfer_mode = 8'b11_01_01_01;
        push(4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0, 0);
        push(4'b0010, 4'b0010, 4'b0000, 1, 0, 0, 0, 0);
        push(4'b0100, 4'b0100, 4'b0000, 1, 0, 1, 2, 0);
        push(4'b1000, 4'b1000, 4'b0000, 1, 2, 0, 0, 1);
        push(4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 0, 0);
        DREQ = 4'b1111;
        runSteps(5, 0);
        cmd_rot_prio = 0;
        waitIdle();

        // demand read ch1, request withdrawn during second transfer's S3
        xfer_type = 8'b00_00_10_00; xfer_mode = 8'b00_00_00_00;
        push(4'b0010, 4'b0010, 4'b0000, 1, 2, 0, 0, 1);
        push(4'b0010, 4'b0010, 4'b0000, 1, 2, 0, 0, 1);
        DREQ = 4'b0010;
        waitFor("demand_first", 2, ok);
        @(posedge CLK); #1;
        @(posedge CLK); #1 DREQ = 0;
        waitFor("demand_second", 2, ok);
        waitIdle();

        // external EOP ends a block read ch0 after one transfer; extended write strobe
        xfer_type = 8'b00_00_00_10; xfer_mode = 8'b00_00_00_10; cmd_ext_wr = 1; EOP_N_IN = 0;
        push(4'b0001, 4'b0001, 4'b0000, 1, 2, 0, 0, 2);
        DREQ = 4'b0001;
        runSteps(1, 0);
        EOP_N_IN = 1; cmd_ext_wr = 0;
        waitIdle();

        // fixed priority with a masked channel and active-low DACK
        xfer_type = 8'b00_00_00_00; xfer_mode = 8'b01_01_01_01; ch_mask = 4'b0010; cmd_dack_hi = 0;
        push(4'b0100, 4'b1011, 4'b0000, 1, 0, 0, 0, 0);
        DREQ = 4'b1110;
        runSteps(1, 0);
        waitIdle();
        check("dack_low_idle", 32'(DACK), 32'hF);
        ch_mask = 0; cmd_dack_hi = 1;

        // HLDA dropped in S2 aborts the transfer
        xfer_type = 8'b00_10_00_00; xfer_mode = 8'b00_01_00_00;
        DREQ = 4'b0100;
        waitFor("abort_s1", 0, ok);
        hldaEn = 0;
        @(posedge CLK);
        #2 check("abort_release", 32'({MEMR_N, IOW_N, AEN, DACK, dp_step}), 32'({1'b1, 1'b1, 1'b0, 4'b0000, 1'b0}));
        @(posedge CLK);
        #2 check("abort_to_si", 32'({HRQ, ch_sel}), 0);
        DREQ = 0;
        waitIdle();
        hldaEn = 1;

        // asynchronous reset while in a wait state
        READY = 0;
        DREQ = 4'b0100;
        waitFor("reset_s3", 1, ok);
        @(posedge CLK);
        @(negedge CLK) RESET = 1;
        #1 check("async_reset_sw", 32'(busVec), 32'(IDLE));
        DREQ = 0; READY = 1;
        @(posedge CLK); #1 RESET = 0;
        waitIdle();

        check("scoreboard_drained", 32'(expQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
